// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial sequence detector with a run-time programmable pattern of up to PAT_W
// bits. Each bit has a don't-care mask, and matches can be overlapping or
// non-overlapping. The match pulse is registered, and a saturating counter
// tracks the number of matches.
//
// Input qualification: in_bit is consumed on every rising clk edge where
// in_valid=1. There is no back-pressure, so the detector always accepts.
// cfg_load has priority over in_valid, and a bit offered in a cfg_load cycle
// is dropped.
//
// Optional build macro SEQ_DETECTOR_TRACE_EN: when it is defined, every
// accepting edge prints a binary trace line (state, in_bit, next history,
// next fill, hit). Ports and timing are identical with or without it.
module seq_detector_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_bit,
   input  logic                         cfg_load,
   input  logic [PAT_W-1:0]             cfg_pattern,
   input  logic [PAT_W-1:0]             cfg_mask,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   input  logic                         cfg_overlap,
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic                         armed
);

   localparam int               LEN_W   = $clog2(PAT_W + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // The FSM state is visible on the armed output (S_ARMED <=> armed=1).
   typedef enum logic [0:0] {
      S_FILL  = 1'b0,
      S_ARMED = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_n;

   // Latched configuration
   logic [PAT_W-1:0]  r_pattern;
   logic [PAT_W-1:0]  r_mask;
   logic [LEN_W-1:0]  r_len;
   logic              r_overlap;

   // History holds the PAT_W-1 most recent bits. The oldest bit of a PAT_W-wide
   // window is always the bit that falls off on the next shift, so the full
   // window exists only as w_hist_n (stored bits plus the incoming bit).
   logic [PAT_W-2:0]  r_hist;
   logic [LEN_W-1:0]  r_fill;
   logic              r_match;
   logic [CNT_W-1:0]  r_count;

   logic [LEN_W-1:0]  w_fill_n;
   logic [LEN_W-1:0]  w_fill_inc;
   logic              w_match_n;
   logic [CNT_W-1:0]  w_count_n;
   logic [LEN_W-1:0]  w_len_cfg;
   logic [PAT_W-1:0]  w_hist_n;
   logic [PAT_W-1:0]  w_len_mask;
   logic [PAT_W-1:0]  w_cmp_en;
   logic              w_bits_ok;
   logic              w_hit;
   logic              w_accept;

   // A bit is taken only when no configuration load competes for the cycle.
   assign w_accept = in_valid & ~cfg_load;

   // A length of zero, or one longer than the register, falls back to the full width.
   always_comb begin
      w_len_cfg = cfg_len;
      if ((cfg_len == '0) || (cfg_len > LEN_MAX)) begin
         w_len_cfg = LEN_MAX;
      end
   end

   // Window after shifting in the current bit. Bit 0 is the newest bit.
   assign w_hist_n = {r_hist, in_bit};

   // Positions inside the active window (k < len). All others are ignored.
   always_comb begin
      w_len_mask = '0;
      for (int k = 0; k < PAT_W; k++) begin
         w_len_mask[k] = (LEN_W'(k) < r_len);
      end
   end

   assign w_cmp_en  = r_mask & w_len_mask;
   assign w_bits_ok = (((w_hist_n ^ r_pattern) & w_cmp_en) == '0);

   // Fill count after accepting this bit. It saturates at len.
   always_comb begin
      w_fill_inc = r_fill;
      if (r_fill < r_len) begin
         w_fill_inc = r_fill + LEN_W'(1);
      end
   end

   // A hit needs a full window and agreement on every compared position.
   assign w_hit = (w_fill_inc >= r_len) && w_bits_ok;

   // Next-state, fill, match and counter decisions
   always_comb begin
      w_state_n = r_state;
      w_fill_n  = r_fill;
      w_match_n = 1'b0;
      w_count_n = r_count;
      if (cfg_load) begin
         w_state_n = S_FILL;
         w_fill_n  = '0;
         w_count_n = '0;
      end else if (in_valid) begin
         w_fill_n  = w_fill_inc;
         w_match_n = w_hit;
         if (w_hit && (r_count != CNT_MAX)) begin
            w_count_n = r_count + CNT_W'(1);
         end
         case (r_state)
            S_FILL: begin
               // A hit on the completing bit counts in both modes. In
               // non-overlapping mode, that hit consumes the window right away.
               if (w_hit && !r_overlap) begin
                  w_fill_n = '0;
               end else if (w_fill_inc == r_len) begin
                  w_state_n = S_ARMED;
               end
            end
            S_ARMED: begin
               if (w_hit && !r_overlap) begin
                  w_state_n = S_FILL;
                  w_fill_n  = '0;
               end
            end
            default: begin
               w_state_n = S_FILL;
               w_fill_n  = '0;
            end
         endcase
      end
   end

   // State and fill registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FILL;
         r_fill  <= '0;
      end else begin
         r_state <= w_state_n;
         r_fill  <= w_fill_n;
      end
   end

   // Registered match pulse and saturating counter. Both update on the accepting edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_match <= 1'b0;
         r_count <= '0;
      end else begin
         r_match <= w_match_n;
         r_count <= w_count_n;
      end
   end

   // Configuration latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern <= '0;
         r_mask    <= '1;
         r_len     <= LEN_MAX;
         r_overlap <= 1'b1;
      end else if (cfg_load) begin
         r_pattern <= cfg_pattern;
         r_mask    <= cfg_mask;
         r_len     <= w_len_cfg;
         r_overlap <= cfg_overlap;
      end
   end

   // History shift register. It is flushed by reset or by a configuration load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist <= '0;
      end else if (cfg_load) begin
         r_hist <= '0;
      end else if (in_valid) begin
         r_hist <= w_hist_n[PAT_W-2:0];
      end
   end

   assign match       = r_match;
   assign match_count = r_count;
   assign armed       = (r_state == S_ARMED);

`ifdef SEQ_DETECTOR_TRACE_EN
   // Print one binary trace line per accepted bit.
   always_ff @(posedge clk) begin
      if (!rst && w_accept) begin
         $display("seq_trace state=%b bit=%b hist=%b fill=%b hit=%b",
                  r_state, in_bit, w_hist_n, w_fill_inc, w_hit);
      end
   end
`else
   // Default build produces no trace output.
`endif

endmodule
